// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - shared AES key-length constants, sequencer state type and Nk helpers
package aes_pkg;

  localparam logic [3:0] NK_128 = 4'd4;
  localparam logic [3:0] NK_192 = 4'd6;
  localparam logic [3:0] NK_256 = 4'd8;
  localparam int         MAX_NR = 14;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT_KS = 2'd1,
    STREAM  = 2'd2
  } seq_state_t;

  function automatic logic [3:0] nr_of(input logic [3:0] nk);
    return nk + 4'd6;
  endfunction

  // Same legality rule the key expander applies when raising its own err.
  function automatic logic nk_valid(input logic [3:0] nk);
    return (nk == NK_128) || (nk == NK_192) || (nk == NK_256);
  endfunction

endpackage

// File: rtl/aes_round_key_sequencer_rk_select.sv
// rtl/aes_round_key_sequencer_rk_select.sv - combinational pick of round key r from a flat schedule
module rk_select #(
  parameter int MAX_NR = 14,
  parameter int WORD_W = 32
) (
  input  logic [4*(MAX_NR+1)*WORD_W-1:0] i_sched,
  input  logic [3:0]                     i_round,
  output logic [4*WORD_W-1:0]            o_key
);

  logic [5:0] w_base;

  assign w_base = {i_round, 2'b00};

  // Word 4r lands in the MSBs of the key.
  always_comb begin
    o_key = '0;
    for (int j = 0; j < 4; j++) begin
      o_key[(3-j)*WORD_W +: WORD_W] = i_sched[(int'(w_base) + j)*WORD_W +: WORD_W];
    end
  end

endmodule

// File: rtl/aes_round_key_sequencer.sv
// rtl/aes_round_key_sequencer.sv - snapshots the expanded key schedule and streams round keys
module aes_round_key_sequencer #(
  parameter int MAX_NR = 14,
  parameter int WORD_W = 32
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           start,
  input  logic                           decrypt,
  input  logic [3:0]                     nk,
  input  logic [4*(MAX_NR+1)*WORD_W-1:0] w_in,
  input  logic                           ks_done,
  input  logic                           ks_err,
  output logic [4*WORD_W-1:0]            rk_data,
  output logic [3:0]                     rk_index,
  output logic                           rk_valid,
  input  logic                           rk_ready,
  output logic                           rk_last,
  output logic                           busy,
  output logic                           err
);

  import aes_pkg::*;

  localparam int NWORDS  = 4*(MAX_NR+1);
  localparam int SCHED_W = NWORDS*WORD_W;

  seq_state_t            r_state;
  seq_state_t            w_next;
  logic [3:0]            r_nk;
  logic                  r_dec;
  logic [SCHED_W-1:0]    r_snap;
  logic [4*WORD_W-1:0]   r_data;
  logic [3:0]            r_idx;
  logic                  r_valid;
  logic                  r_last;
  logic                  r_err;

  logic [3:0]            w_nr;
  logic [3:0]            w_sel_r;
  logic [SCHED_W-1:0]    w_sel_src;
  logic [4*WORD_W-1:0]   w_sel_key;
  logic                  w_next_last;
  logic                  w_accept;
  logic                  w_reject;
  logic                  w_load;
  logic                  w_advance;
  logic                  w_finish;

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (start && nk_valid(nk) && !ks_err) w_next = WAIT_KS;
      WAIT_KS: if (ks_err) w_next = IDLE;
               else if (ks_done) w_next = STREAM;
      STREAM:  if (r_valid && rk_ready && r_last) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    w_accept  = 1'b0;
    w_reject  = 1'b0;
    w_load    = 1'b0;
    w_advance = 1'b0;
    w_finish  = 1'b0;
    busy      = (r_state != IDLE);
    case (r_state)
      IDLE: begin
        if (start) begin
          if (!nk_valid(nk) || ks_err) w_reject = 1'b1;
          else                         w_accept = 1'b1;
        end
      end
      WAIT_KS: begin
        if (ks_err)       w_reject = 1'b1;
        else if (ks_done) w_load   = 1'b1;
      end
      STREAM: begin
        if (r_valid && rk_ready) begin
          if (r_last) w_finish  = 1'b1;
          else        w_advance = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // The first key is taken straight from w_in because the snapshot fills on the same edge.
  assign w_nr        = nr_of(r_nk);
  assign w_sel_src   = (r_state == WAIT_KS) ? w_in : r_snap;
  assign w_sel_r     = (r_state == WAIT_KS) ? (r_dec ? w_nr : 4'd0)
                                            : (r_dec ? r_idx - 4'd1 : r_idx + 4'd1);
  assign w_next_last = r_dec ? (w_sel_r == 4'd0) : (w_sel_r == w_nr);

  rk_select #(
    .MAX_NR (MAX_NR),
    .WORD_W (WORD_W)
  ) u_rk_select (
    .i_sched (w_sel_src),
    .i_round (w_sel_r),
    .o_key   (w_sel_key)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_nk    <= 4'd0;
      r_dec   <= 1'b0;
      r_snap  <= '0;
      r_data  <= '0;
      r_idx   <= 4'd0;
      r_valid <= 1'b0;
      r_last  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_err <= w_reject;
      if (w_accept) begin
        r_nk  <= nk;
        r_dec <= decrypt;
      end
      if (w_load) begin
        for (int k = 0; k < NWORDS; k++) begin
          if (k < 4*(int'(w_nr) + 1)) r_snap[k*WORD_W +: WORD_W] <= w_in[k*WORD_W +: WORD_W];
        end
      end
      if (w_load || w_advance) begin
        r_data  <= w_sel_key;
        r_idx   <= w_sel_r;
        r_valid <= 1'b1;
        r_last  <= w_next_last;
      end else if (w_finish) begin
        r_valid <= 1'b0;
        r_last  <= 1'b0;
      end
    end
  end

  assign rk_data  = r_data;
  assign rk_index = r_idx;
  assign rk_valid = r_valid;
  assign rk_last  = r_last;
  assign err      = r_err;

endmodule

// File: tb/tb_aes_round_key_sequencer.sv
// tb/tb_aes_round_key_sequencer.sv - scoreboard bench for aes_round_key_sequencer
module tb_aes_round_key_sequencer;

  logic          clk = 1'b0;
  logic          rst, start, decrypt, ks_done, ks_err, rk_ready;
  logic [3:0]    nk;
  logic [1919:0] w_in;
  logic [127:0]  rk_data;
  logic [3:0]    rk_index;
  logic          rk_valid, rk_last, busy, err;

  always #5 clk = ~clk;

  aes_round_key_sequencer dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .decrypt  (decrypt),
    .nk       (nk),
    .w_in     (w_in),
    .ks_done  (ks_done),
    .ks_err   (ks_err),
    .rk_data  (rk_data),
    .rk_index (rk_index),
    .rk_valid (rk_valid),
    .rk_ready (rk_ready),
    .rk_last  (rk_last),
    .busy     (busy),
    .err      (err)
  );

  typedef struct {
    logic [3:0]   idx;
    logic [127:0] data;
    logic         last;
  } exp_t;

  exp_t         sb[$];
  int           n_pass = 0;
  int           n_total = 0;
  int           got_keys, stream_cycles;
  logic [127:0] first_data, last_data;
  logic [3:0]   first_idx, last_idx;

  logic [255:0] k128 = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
  logic [255:0] k192 = {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0};
  logic [255:0] k256 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

  // Reference key expansion: S-box from GF(2^8) inverse plus affine map.
  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x, y;
    p = 8'h00; x = a; y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = xtime(x);
      y = y >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] b);
    logic [7:0] inv;
    inv = 8'h00;
    if (b != 8'h00) begin
      inv = 8'h01;
      for (int i = 0; i < 254; i++) inv = gmul(inv, b);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
               ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [31:0] subw(input logic [31:0] t);
    return {sbox(t[31:24]), sbox(t[23:16]), sbox(t[15:8]), sbox(t[7:0])};
  endfunction

  function automatic logic [1919:0] expand(input logic [255:0] key, input int nkw);
    logic [31:0]   w [60];
    logic [31:0]   t;
    logic [7:0]    rc;
    logic [1919:0] res;
    int            nw;
    nw = 4*(nkw + 7);
    rc = 8'h01;
    res = '0;
    for (int i = 0; i < 60; i++) w[i] = 32'h0;
    for (int i = 0; i < nkw; i++) w[i] = key[255-32*i -: 32];
    for (int i = nkw; i < nw; i++) begin
      t = w[i-1];
      if (i % nkw == 0) begin
        t = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = xtime(rc);
      end else if (nkw > 6 && i % nkw == 4) begin
        t = subw(t);
      end
      w[i] = w[i-nkw] ^ t;
    end
    for (int i = 0; i < nw; i++) res[32*i +: 32] = w[i];
    return res;
  endfunction

  task automatic push_stream(input logic [1919:0] sched, input int nkw, input logic dec);
    exp_t e;
    int   nr, r;
    nr = nkw + 6;
    for (int k = 0; k <= nr; k++) begin
      r = dec ? nr - k : k;
      e.idx  = 4'(r);
      e.data = {sched[32*(4*r) +: 32], sched[32*(4*r+1) +: 32],
                sched[32*(4*r+2) +: 32], sched[32*(4*r+3) +: 32]};
      e.last = (k == nr);
      sb.push_back(e);
    end
  endtask

  task automatic do_start(input logic [3:0] nk_v, input logic dec);
    @(negedge clk);
    start = 1'b1; nk = nk_v; decrypt = dec;
    @(negedge clk);
    start = 1'b0; nk = 4'd5; decrypt = ~dec;
  endtask

  // Pops the scoreboard on every handshake; also checks outputs hold across stalls.
  task automatic drain(input int ready_pct, input int corrupt_at);
    int           budget;
    logic         held, seen;
    logic [127:0] hd;
    logic [3:0]   hi;
    exp_t         e;
    got_keys = 0; stream_cycles = 0; budget = 0; held = 1'b0; seen = 1'b0;
    hd = '0; hi = '0;
    while (sb.size() > 0 && budget < 600) begin
      @(negedge clk);
      budget++;
      rk_ready = ($urandom_range(99) < ready_pct);
      if (rk_valid) seen = 1'b1;
      if (seen) stream_cycles++;
      if (held) begin
        n_total++;
        if (rk_data !== hd || rk_index !== hi)
          $display("FAIL stall_hold got %h/%0d want %h/%0d", rk_data, rk_index, hd, hi);
        else n_pass++;
      end
      if (rk_valid && rk_ready) begin
        e = sb.pop_front();
        n_total++;
        if (rk_data !== e.data || rk_index !== e.idx || rk_last !== e.last)
          $display("FAIL key got %h/%0d/%0b want %h/%0d/%0b",
                   rk_data, rk_index, rk_last, e.data, e.idx, e.last);
        else n_pass++;
        if (got_keys == 0) begin first_data = rk_data; first_idx = rk_index; end
        last_data = rk_data; last_idx = rk_index;
        got_keys++;
        if (got_keys == corrupt_at) begin
          w_in = ~w_in; ks_done = 1'b0; ks_err = 1'b1;
        end
      end
      held = rk_valid && !rk_ready;
      hd = rk_data; hi = rk_index;
    end
    if (sb.size() > 0) begin
      n_total++;
      $display("FAIL drain_timeout got %0d keys, %0d still expected", got_keys, sb.size());
      sb.delete();
    end
    @(negedge clk);
    rk_ready = 1'b0;
    n_total++;
    if (busy !== 1'b0 || rk_valid !== 1'b0 || rk_last !== 1'b0)
      $display("FAIL end_of_stream got busy=%0b valid=%0b last=%0b want 0/0/0", busy, rk_valid, rk_last);
    else n_pass++;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    n_total++;
    if (rk_data !== 128'h0 || rk_index !== 4'd0) $display("FAIL reset_data got %h/%0d want 0/0", rk_data, rk_index);
    else n_pass++;
    n_total++;
    if (rk_valid !== 1'b0 || rk_last !== 1'b0 || busy !== 1'b0 || err !== 1'b0)
      $display("FAIL reset_flags got valid=%0b last=%0b busy=%0b err=%0b want 0", rk_valid, rk_last, busy, err);
    else n_pass++;
    rst = 1'b0;
  endtask

  task automatic test_aes128_enc;
    w_in = expand(k128, 4); ks_done = 1'b1; ks_err = 1'b0;
    push_stream(w_in, 4, 1'b0);
    do_start(4'd4, 1'b0);
    n_total++;
    if (rk_valid !== 1'b0 || busy !== 1'b1) $display("FAIL enc_wait got valid=%0b busy=%0b want 0/1", rk_valid, busy);
    else n_pass++;
    drain(100, 0);
    n_total++;
    if (got_keys !== 11 || stream_cycles !== 11)
      $display("FAIL enc_count got %0d keys in %0d cycles want 11/11", got_keys, stream_cycles);
    else n_pass++;
    n_total++;
    if (first_data !== k128[255:128] || first_idx !== 4'd0) $display("FAIL enc_first got %h/%0d want %h/0", first_data, first_idx, k128[255:128]);
    else n_pass++;
    n_total++;
    if (last_data !== 128'hd014f9a8c9ee2589e13f0cc8b6630ca6 || last_idx !== 4'd10)
      $display("FAIL enc_last got %h/%0d want d014f9a8c9ee2589e13f0cc8b6630ca6/10", last_data, last_idx);
    else n_pass++;
  endtask

  task automatic test_aes128_dec;
    w_in = expand(k128, 4); ks_done = 1'b1;
    push_stream(w_in, 4, 1'b1);
    do_start(4'd4, 1'b1);
    drain(100, 0);
    n_total++;
    if (got_keys !== 11) $display("FAIL dec_count got %0d want 11", got_keys);
    else n_pass++;
    n_total++;
    if (first_data !== 128'hd014f9a8c9ee2589e13f0cc8b6630ca6 || first_idx !== 4'd10)
      $display("FAIL dec_first got %h/%0d want d014f9a8c9ee2589e13f0cc8b6630ca6/10", first_data, first_idx);
    else n_pass++;
    n_total++;
    if (last_data !== k128[255:128] || last_idx !== 4'd0) $display("FAIL dec_last got %h/%0d want %h/0", last_data, last_idx, k128[255:128]);
    else n_pass++;
  endtask

  task automatic test_aes256_stall;
    w_in = expand(k256, 8); ks_done = 1'b1;
    push_stream(w_in, 8, 1'b0);
    do_start(4'd8, 1'b0);
    drain(55, 0);
    n_total++;
    if (got_keys !== 15 || last_idx !== 4'd14) $display("FAIL a256_count got %0d last=%0d want 15/14", got_keys, last_idx);
    else n_pass++;
    n_total++;
    if (first_data !== k256[255:128] || first_idx !== 4'd0) $display("FAIL a256_first got %h/%0d want %h/0", first_data, first_idx, k256[255:128]);
    else n_pass++;
  endtask

  task automatic test_err;
    ks_done = 1'b0; ks_err = 1'b0;
    for (int pass = 0; pass < 3; pass++) begin
      if (pass == 1) ks_err = 1'b1;
      do_start(pass == 0 ? 4'd5 : 4'd4, 1'b0);
      if (pass == 2) begin
        n_total++;
        if (busy !== 1'b1 || err !== 1'b0) $display("FAIL err_wait got busy=%0b err=%0b want 1/0", busy, err);
        else n_pass++;
        ks_err = 1'b1;
        @(negedge clk);
      end
      n_total++;
      if (err !== 1'b1 || busy !== 1'b0 || rk_valid !== 1'b0)
        $display("FAIL err_pulse%0d got err=%0b busy=%0b valid=%0b want 1/0/0", pass, err, busy, rk_valid);
      else n_pass++;
      @(negedge clk);
      ks_err = 1'b0;
      n_total++;
      if (err !== 1'b0 || busy !== 1'b0 || rk_valid !== 1'b0)
        $display("FAIL err_clear%0d got err=%0b busy=%0b valid=%0b want 0/0/0", pass, err, busy, rk_valid);
      else n_pass++;
    end
  endtask

  task automatic test_wait_ks;
    int bad;
    w_in = expand(k128, 4); ks_done = 1'b0; ks_err = 1'b0;
    push_stream(w_in, 4, 1'b0);
    do_start(4'd4, 1'b0);
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (rk_valid !== 1'b0 || busy !== 1'b1) bad++;
    end
    n_total++;
    if (bad != 0) $display("FAIL wait_hold got %0d bad cycles want 0", bad);
    else n_pass++;
    ks_done = 1'b1;
    @(negedge clk);
    n_total++;
    if (rk_valid !== 1'b1) $display("FAIL wait_release got valid=%0b want 1", rk_valid);
    else n_pass++;
    drain(100, 3);
    ks_err = 1'b0; ks_done = 1'b1;
    n_total++;
    if (got_keys !== 11) $display("FAIL corrupt_count got %0d want 11", got_keys);
    else n_pass++;
  endtask

  task automatic test_reset_midstream;
    logic found;
    w_in = expand(k192, 6); ks_done = 1'b1; ks_err = 1'b0;
    do_start(4'd6, 1'b0);
    rk_ready = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clk);
      if (rk_valid === 1'b1 && rk_index === 4'd5) found = 1'b1;
    end
    n_total++;
    if (!found) $display("FAIL rst_reach got index %0d want 5", rk_index);
    else n_pass++;
    rst = 1'b1; rk_ready = 1'b0;
    @(negedge clk);
    n_total++;
    if (rk_data !== 128'h0 || rk_index !== 4'd0 || rk_valid !== 1'b0 || rk_last !== 1'b0 || busy !== 1'b0 || err !== 1'b0)
      $display("FAIL rst_mid got %h/%0d valid=%0b last=%0b busy=%0b err=%0b want all 0",
               rk_data, rk_index, rk_valid, rk_last, busy, err);
    else n_pass++;
    rst = 1'b0;
    push_stream(w_in, 6, 1'b0);
    do_start(4'd6, 1'b0);
    drain(100, 0);
    n_total++;
    if (got_keys !== 13 || last_idx !== 4'd12) $display("FAIL a192_count got %0d last=%0d want 13/12", got_keys, last_idx);
    else n_pass++;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; decrypt = 1'b0; nk = 4'd0; w_in = '0;
    ks_done = 1'b0; ks_err = 1'b0; rk_ready = 1'b0;
    test_reset();
    test_aes128_enc();
    test_aes128_dec();
    test_aes256_stall();
    test_err();
    test_wait_ks();
    test_reset_midstream();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/aes_round_key_sequencer.md
Name: aes_round_key_sequencer

Overview:
Consumer side of the AES key-expansion block. It snapshots the expanded key schedule once expansion reports completion, then streams one 128-bit round key per valid/ready handshake to the cipher datapath. Encryption uses forward order (round 0..Nr) and decryption uses reverse order (round Nr..0). It sits between the key-expansion block and the round engine, and decouples the cipher from the expander's reset and recompute activity.

Parameters:
MAX_NR, 14, maximum round count supported; sizes the snapshot to 4*(MAX_NR+1) words.
WORD_W, 32, key-schedule word width.

Ports:
clk  input  1  clock, rising edge
rst  input  1  reset, synchronous, active-high
start  input  1  one-cycle request to begin a key stream; ignored unless idle
decrypt  input  1  sampled with start: 0 = forward order, 1 = reverse order
nk  input  4  key length in words (4, 6 or 8); sampled with start
w_in  input  1920  expanded schedule; word k at w_in[32k+31:32k]
ks_done  input  1  schedule complete and w_in stable
ks_err  input  1  key-expansion reports invalid Nk
rk_data  output  128  current round key {w[4r], w[4r+1], w[4r+2], w[4r+3]}, w[4r] in MSBs
rk_index  output  4  round number r of rk_data
rk_valid  output  1  rk_data/rk_index/rk_last valid
rk_ready  input  1  consumer accepts the current key
rk_last  output  1  current key is the final one of the stream
busy  output  1  high in any state other than IDLE
err  output  1  one-cycle pulse on a rejected start

Behaviour:
- Reset: state IDLE. rk_data=0, rk_index=0, rk_valid=0, rk_last=0, busy=0, err=0. The snapshot is cleared to 0. Reset takes priority over every other event, including mid-stream.
- Nr = nk + 6, computed in 4 bits. Valid nk values are 4, 6 and 8 only.
- State IDLE:
  - start=1 with an invalid nk, or with ks_err=1: err=1 for the next cycle only; stay IDLE.
  - start=1 otherwise: latch nk and decrypt; go to WAIT_KS.
- State WAIT_KS:
  - ks_err=1: pulse err and return to IDLE. ks_err has priority over ks_done.
  - Else if ks_done=1 at the edge: copy the 4*(Nr+1) active words of w_in into the snapshot. At the same edge, load the first key: r=0 if encrypting, r=Nr if decrypting. Set rk_valid=1 and go to STREAM.
  - Minimum latency: start sampled at edge 0, ks_done sampled at edge 1, rk_valid high after edge 1.
- State STREAM:
  - rk_data, rk_index and rk_last are registered and held stable while rk_valid=1 and rk_ready=0.
  - On rk_valid & rk_ready: advance r (+1 when encrypting, -1 when decrypting) and load the next key from the snapshot at the same edge. There is no bubble between keys, so throughput is 1 key per cycle under continuous ready.
  - rk_last=1 exactly when r==Nr (encrypt) or r==0 (decrypt).
  - Handshake on the last key: rk_valid=0, rk_last=0, go to IDLE. Accepting a new start takes one further cycle.
- Once captured, the stream is sourced only from the snapshot. Changes on w_in, ks_done or ks_err during STREAM have no effect.
- start, decrypt and nk are ignored while busy.
- Total handshakes per stream: Nr+1 (11, 13 or 15).

Decomposition:
- Shared package aes_pkg:
  - constants NK_128=4, NK_192=6, NK_256=8, MAX_NR=14;
  - the state enum IDLE/WAIT_KS/STREAM;
  - function nr_of(nk);
  - function nk_valid(nk) (the same legality rule the key expander uses for its err output).
- One natural sub-module, rk_select: combinational. Given the snapshot and r, it returns the 128-bit round key with w[4r] in the MSBs. The sequencer instantiates it once and registers its output.

Test Plan:
- AES-128 encrypt, FIPS-197 key 2b7e151628aed2a6abf7158809cf4f3c, rk_ready=1 throughout:
  - first key equals the cipher key at rk_index=0;
  - 11 consecutive-cycle handshakes;
  - rk_index=10 gives d014f9a8c9ee2589e13f0cc8b6630ca6 with rk_last=1;
  - busy=0 one cycle later.
- Same key with decrypt=1: first key d014f9a8c9ee2589e13f0cc8b6630ca6 at rk_index=10; last key 2b7e1516... at rk_index=0 with rk_last=1.
- AES-256 (nk=8) with random rk_ready stalls:
  - exactly 15 keys in order 0..14;
  - rk_data/rk_index stable across every stall cycle;
  - rk_index=0 key equals key bits [255:128] of the FIPS-197 256-bit vector.
- start with nk=5, and separately start with ks_err=1: err=1 for exactly one cycle; rk_valid never asserts; busy=0.
- start while ks_done=0: remain in WAIT_KS for 20 cycles with rk_valid=0; raise ks_done; first key appears after that edge. Then corrupt w_in mid-STREAM: later keys still match the captured values.
- rst asserted at rk_index=5 of an AES-192 stream: next cycle all outputs 0 and state IDLE; a new start then streams 13 keys correctly.
